// File: rtl/demux_1x8_16_seq.sv
// 1-to-8 sequencing demultiplexer. Words are steered into held channel registers,
// either by explicit address or by a rotating write pointer, with per-frame completion tracking.
module demux_1x8_16_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic [2:0]   in_sel,
  input  logic         mode,
  input  logic         clr,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [W-1:0] o4,
  output logic [W-1:0] o5,
  output logic [W-1:0] o6,
  output logic [W-1:0] o7,
  output logic [7:0]   vld,
  output logic [2:0]   ptr,
  output logic         frame_done,
  output logic         overrun
);

  logic [W-1:0] o_q [8];
  logic [W-1:0] o_d [8];
  logic [7:0]   vld_q, vld_d;
  logic [2:0]   ptr_q, ptr_d;
  logic         frame_done_q, frame_done_d;
  logic         overrun_q, overrun_d;

  logic         accept;
  logic [2:0]   ch;
  logic [7:0]   ch_onehot;
  logic [7:0]   nv;

  assign accept    = in_valid && !clr;
  assign ch        = mode ? ptr_q : in_sel;
  assign ch_onehot = 8'b1 << ch;
  assign nv        = vld_q | ch_onehot;

  // clr wins over a simultaneous word; channel data is never touched by clr
  always_comb begin
    o_d          = o_q;
    vld_d        = vld_q;
    ptr_d        = ptr_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    if (clr) begin
      vld_d     = 8'h00;
      ptr_d     = 3'd0;
      overrun_d = 1'b0;
    end else if (accept) begin
      o_d[ch] = in_data;
      if (mode) begin
        ptr_d = ptr_q + 3'd1;
      end
      if (vld_q[ch]) begin
        overrun_d = 1'b1;
      end
      if (nv == 8'hFF) begin
        vld_d        = 8'h00;
        frame_done_d = 1'b1;
      end else begin
        vld_d = nv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        o_q[k] <= '0;
      end
      vld_q        <= 8'h00;
      ptr_q        <= 3'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      o_q          <= o_d;
      vld_q        <= vld_d;
      ptr_q        <= ptr_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o0         = o_q[0];
  assign o1         = o_q[1];
  assign o2         = o_q[2];
  assign o3         = o_q[3];
  assign o4         = o_q[4];
  assign o5         = o_q[5];
  assign o6         = o_q[6];
  assign o7         = o_q[7];
  assign vld        = vld_q;
  assign ptr        = ptr_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1x8_16_seq.sv
// Directed self-checking bench for demux_1x8_16_seq: addressed and sequential fills,
// overrun, idle gaps, clr priority and asynchronous reset.
module tb_demux_1x8_16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_sel = '0;
  logic        mode = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  vld;
  logic [2:0]  ptr;
  logic        frame_done;
  logic        overrun;

  logic [15:0] o_obs [8];
  logic [15:0] exp_o [8];
  int checks = 0;
  int failures = 0;

  demux_1x8_16_seq #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sel(in_sel), .mode(mode), .clr(clr),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .vld(vld), .ptr(ptr), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  assign o_obs[0] = o0;
  assign o_obs[1] = o1;
  assign o_obs[2] = o2;
  assign o_obs[3] = o3;
  assign o_obs[4] = o4;
  assign o_obs[5] = o5;
  assign o_obs[6] = o6;
  assign o_obs[7] = o7;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // drive one cycle of inputs, then return 1 ns after the capturing edge
  task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic m,
                               input logic [15:0] d, input logic c);
    in_valid = v;
    in_sel   = sel;
    mode     = m;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic checkChannels(input string tag);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s_o%0d", tag, k), {16'd0, o_obs[k]}, {16'd0, exp_o[k]});
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s_o%0d", tag, k), {16'd0, o_obs[k]}, 32'd0);
    end
    checkOutput({tag, "_vld"}, {24'd0, vld}, 32'd0);
    checkOutput({tag, "_ptr"}, {29'd0, ptr}, 32'd0);
    checkOutput({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    checkOutput({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    logic [15:0] fill_vals [8];
    logic [15:0] seq_vals [9];
    logic [2:0]  ooo_sel [8];
    fill_vals = '{16'd6234, 16'd725, 16'd7524, 16'd5734, 16'd8354, 16'd28457, 16'd2458, 16'd2547};
    seq_vals  = '{16'd384, 16'd398, 16'd9337, 16'd9353, 16'd2457, 16'd8542, 16'd3659, 16'd2854, 16'd65535};
    ooo_sel   = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    for (int k = 0; k < 8; k++) exp_o[k] = '0;

    // reset, including an accept offered while held in reset
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst");
    in_valid = 1'b1; in_data = 16'd999; in_sel = 3'd3;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid = 1'b0;
    checkAllZero("rst_hold");

    // addressed fill
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b0, fill_vals[i], 1'b0);
      exp_o[i] = fill_vals[i];
      if (i < 7) checkOutput($sformatf("fill_fd_%0d", i), {31'd0, frame_done}, 32'd0);
    end
    checkOutput("fill_fd", {31'd0, frame_done}, 32'd1);
    checkOutput("fill_vld", {24'd0, vld}, 32'd0);
    checkOutput("fill_ptr", {29'd0, ptr}, 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("fill_fd_off", {31'd0, frame_done}, 32'd0);
    checkChannels("fill");

    // sequential wrap, with mode/sel toggling while idle
    applyStimulus(1'b0, 3'd5, 1'b1, 16'd1, 1'b0);
    checkOutput("seq_ptr0", {29'd0, ptr}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 3'd6, 1'b1, seq_vals[i], 1'b0);
      exp_o[i % 8] = seq_vals[i];
      if (i == 7) begin
        checkOutput("seq_fd", {31'd0, frame_done}, 32'd1);
        checkOutput("seq_ptr_wrap", {29'd0, ptr}, 32'd0);
      end else begin
        checkOutput($sformatf("seq_fd_%0d", i), {31'd0, frame_done}, 32'd0);
      end
    end
    checkOutput("seq_o0", {16'd0, o0}, 32'd65535);
    checkOutput("seq_ptr", {29'd0, ptr}, 32'd1);
    checkOutput("seq_vld", {24'd0, vld}, 32'h01);
    checkOutput("seq_ovr", {31'd0, overrun}, 32'd0);
    checkChannels("seq");
    applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("mode_ptr_hold", {29'd0, ptr}, 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b1);
    checkOutput("clr_ptr", {29'd0, ptr}, 32'd0);
    checkOutput("clr_vld", {24'd0, vld}, 32'd0);

    // overrun
    applyStimulus(1'b1, 3'd2, 1'b0, 16'd136, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 16'd8564, 1'b0);
    exp_o[2] = 16'd8564;
    checkOutput("ovr_o2", {16'd0, o2}, 32'd8564);
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_vld", {24'd0, vld}, 32'h04);
    checkOutput("ovr_fd", {31'd0, frame_done}, 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b1);
    checkOutput("ovr_clr_flag", {31'd0, overrun}, 32'd0);
    checkOutput("ovr_clr_vld", {24'd0, vld}, 32'd0);
    checkOutput("ovr_clr_o2", {16'd0, o2}, 32'd8564);

    // out-of-order fill with idle gaps
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h1000 + 16'(ooo_sel[i]) * 16'd17;
      applyStimulus(1'b1, ooo_sel[i], 1'b0, d, 1'b0);
      exp_o[ooo_sel[i]] = d;
      checkOutput($sformatf("ooo_fd_w%0d", i), {31'd0, frame_done}, (i == 7) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 3'(i), 1'b1, 16'hDEAD, 1'b0);
      checkOutput($sformatf("ooo_fd_g%0d", i), {31'd0, frame_done}, 32'd0);
    end
    checkOutput("ooo_vld", {24'd0, vld}, 32'd0);
    checkOutput("ooo_ovr", {31'd0, overrun}, 32'd0);
    checkChannels("ooo");

    // clr beats a simultaneous word
    applyStimulus(1'b1, 3'd0, 1'b0, 16'd4321, 1'b0);
    exp_o[0] = 16'd4321;
    checkOutput("pri_vld_pre", {24'd0, vld}, 32'h01);
    applyStimulus(1'b1, 3'd5, 1'b0, 16'd54287, 1'b1);
    checkOutput("pri_o5", {16'd0, o5}, {16'd0, exp_o[5]});
    checkOutput("pri_vld", {24'd0, vld}, 32'd0);
    checkChannels("pri");

    // async reset mid-frame
    applyStimulus(1'b1, 3'd1, 1'b0, 16'd111, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 16'd222, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0, 16'd333, 1'b0);
    checkOutput("mid_vld", {24'd0, vld}, 32'h0E);
    #2 rst_n = 1'b0;
    #1 checkAllZero("mid_rst");
    #3 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_o[k] = '0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
      checkOutput($sformatf("post_fd_%0d", i), {31'd0, frame_done}, 32'd0);
    end
    applyStimulus(1'b1, 3'd3, 1'b0, 16'd777, 1'b0);
    checkOutput("post_o3", {16'd0, o3}, 32'd777);
    checkOutput("post_vld", {24'd0, vld}, 32'h08);
    checkOutput("post_fd", {31'd0, frame_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1x8_16_seq.md
DEMUX_1X8_16_SEQ -- requirements
Module: demux_1x8_16_seq

Interface
REQ-001 The module SHALL have a parameter W, default 16, giving the data width of the input and of each output channel.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port in_data, input, W bits: incoming multiplexed word.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data is offered for capture this cycle.
REQ-006 The module SHALL have port in_sel, input, 3 bits: destination channel when mode=0.
REQ-007 The module SHALL have port mode, input, 1 bit: 0 = addressed (in_sel), 1 = sequential (internal pointer).
REQ-008 The module SHALL have port clr, input, 1 bit: synchronous clear of the frame state.
REQ-009 The module SHALL have ports o0..o7, output, W bits each: held channel registers.
REQ-010 The module SHALL have port vld, output, 8 bits: bit k set means channel k was written in the current frame.
REQ-011 The module SHALL have port ptr, output, 3 bits: sequential-mode write pointer.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse when all 8 channels are written.
REQ-013 The module SHALL have port overrun, output, 1 bit: sticky flag set when a channel is rewritten within a frame.

Function
REQ-014 An accept SHALL occur on a rising clk edge with in_valid=1 and clr=0.
REQ-015 Destination ch SHALL be in_sel when mode=0 and ptr when mode=1, sampled in the accept cycle.
REQ-016 On accept, o[ch] SHALL load in_data, visible one cycle after the edge (latency 1); all other o[k] hold.
REQ-017 Outputs o0..o7 SHALL hold their value indefinitely when there is no accept.
REQ-018 On accept in mode=1, ptr SHALL increment modulo 8 (7 -> 0).
REQ-019 In mode=0, ptr SHALL hold; changing mode SHALL NOT alter ptr.
REQ-020 On accept with vld[ch]=1 already set, overrun SHALL set to 1 and stay set until reset or clr; the data write still occurs.
REQ-021 Let nv = vld OR onehot(ch); on accept, if nv = 8'hFF then vld SHALL load 0 and frame_done SHALL be 1 for the next cycle only; otherwise vld SHALL load nv.
REQ-022 frame_done SHALL be 0 in every cycle not covered by REQ-021; back-to-back frames SHALL produce separate pulses.
REQ-023 clr=1 SHALL clear vld, ptr, overrun and frame_done next cycle, leave o0..o7 unchanged, and drop any simultaneous in_valid word (clr has priority).
REQ-024 in_sel and mode SHALL be ignored when in_valid=0.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force o0..o7=0, vld=0, ptr=0, frame_done=0, overrun=0.
REQ-026 While rst_n=0, accepts SHALL be ignored; the first accept SHALL occur on the first rising edge after rst_n deasserts.
REQ-027 Reset asserted mid-frame SHALL discard partial frame state; no frame_done SHALL follow.

Verification
REQ-028 Addressed fill: mode=0; write 6234, 725, 7524, 5734, 8354, 28457, 2458, 2547 to sel 0..7 on consecutive cycles -> o0..o7 equal these values; frame_done pulses once, one cycle after the sel=7 write; vld returns to 0.
REQ-029 Sequential wrap: mode=1, ptr=0; 9 accepts of 384, 398, 9337, 9353, 2457, 8542, 3659, 2854, 65535 -> frame_done after the 8th; o0=65535; ptr=1; vld=8'h01.
REQ-030 Overrun: mode=0; write 136 to sel 2, then 8564 to sel 2 -> o2=8564, overrun=1, vld=8'h04, no frame_done; clr -> overrun=0, vld=0, o2 still 8564.
REQ-031 Out-of-order with idle gaps: mode=0, sel order 7, 3, 0, 5, 1, 6, 2, 4, in_valid toggling 1/0 -> frame_done only after sel=4; each o matches its written value.
REQ-032 Clr and reset priority: clr=1 with in_valid=1, data 54287 to sel 5 -> o5 unchanged, vld=0. rst_n pulsed low mid-cycle after 3 writes -> all outputs 0 immediately; no frame_done afterward.
